noc_filereg_responder: RTL and testbench

Tile-side endpoint for NoC configuration register access: consumes request packets from the router local ejection port, executes reads and writes on a local configuration register file, and injects response packets back into the NoC toward the requesting tile. It is the responder paired with the NoC Controller's request traffic; one instance sits in every tile.

---
 rtl/noc_filereg_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_noc_filereg_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_filereg_responder.sv
// noc_filereg_responder
// Tile-side NoC endpoint that serves configuration register reads/writes.
// It accepts one request packet at a time from the local ejection port,
// executes it on the local register file and injects the response packet
// back toward the requesting tile. Register 0 is read-only and holds the
// tile address.
module noc_filereg_responder #(
    parameter int NetworkSwitchAddressId      = 0,
    parameter int NetworkSwitchAddressIdWidth = 4,
    parameter int NetworkFlitWidth            = 64,
    parameter int NetworkFlitTypeWidth        = 2,
    parameter int NumberOfRegisters           = 16,
    parameter int RegisterWidth               = 32
) (
    input  logic                                             clk_network_i,
    input  logic                                             rst_network_i,
    input  logic                                             network_valid_i,
    input  logic [NetworkFlitTypeWidth+NetworkFlitWidth-1:0] network_data_i,
    output logic                                             network_go_o,
    output logic                                             network_valid_o,
    output logic [NetworkFlitTypeWidth+NetworkFlitWidth-1:0] network_data_o,
    input  logic                                             network_go_i,
    output logic [NumberOfRegisters*RegisterWidth-1:0]       filereg_q_o,
    output logic [7:0]                                       err_count_o
);

    localparam int W  = NetworkSwitchAddressIdWidth;
    localparam int FW = NetworkFlitWidth;
    localparam int TW = NetworkFlitTypeWidth;
    localparam int DW = TW + FW;
    localparam int N  = NumberOfRegisters;
    localparam int RW = RegisterWidth;

    localparam logic [W-1:0]  OWN_ID   = W'(NetworkSwitchAddressId);
    localparam logic [RW-1:0] REG0_VAL = RW'(NetworkSwitchAddressId);
    localparam logic [8:0]    NUM_REGS = 9'(N);

    localparam logic [1:0] FT_HEADER      = 2'b00;
    localparam logic [1:0] FT_BODY        = 2'b01;
    localparam logic [1:0] FT_TAIL        = 2'b10;
    localparam logic [1:0] FT_HEADER_TAIL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_RESP_HDR  = 2'd2,
        S_RESP_TAIL = 2'd3
    } state_t;

    // Builds a response header flit; every bit outside the defined fields is 0.
    function automatic logic [FW-1:0] make_header(
        input logic [W-1:0] dst,
        input logic         op,
        input logic [7:0]   idx,
        input logic [7:0]   tag,
        input logic         status
    );
        logic [FW-1:0] f;
        f                  = '0;
        f[W-1:0]           = dst;
        f[2*W-1:W]         = OWN_ID;
        f[2*W]             = op;
        f[2*W+8:2*W+1]     = idx;
        f[2*W+16:2*W+9]    = tag;
        f[2*W+17]          = status;
        return f;
    endfunction

    // Builds a data-carrying tail flit with the payload in the low bits.
    function automatic logic [FW-1:0] make_tail(input logic [RW-1:0] data);
        logic [FW-1:0] f;
        f         = '0;
        f[RW-1:0] = data;
        return f;
    endfunction

    state_t        r_state;
    state_t        w_state_next;
    logic          r_go_en;
    logic [W-1:0]  r_req_src;
    logic          r_op;
    logic [7:0]    r_idx;
    logic [7:0]    r_tag;
    logic          r_status;
    logic [RW-1:0] r_rdata;
    logic [7:0]    r_err;
    logic [RW-1:0] r_regs [1:N-1];

    logic          w_capture;
    logic          w_err_inc;
    logic          w_wr_en;
    logic          w_accept;
    logic [1:0]    w_type;
    logic [FW-1:0] w_flit;
    logic [W-1:0]  w_dst;
    logic [W-1:0]  w_src;
    logic          w_op;
    logic [7:0]    w_idx;
    logic [7:0]    w_tag;
    logic          w_own;
    logic          w_idx_oob;
    logic          w_req_err;
    logic [RW-1:0] w_rd_val;
    logic          w_unused_bits;

    assign w_type    = network_data_i[DW-1:FW];
    assign w_flit    = network_data_i[FW-1:0];
    assign w_dst     = w_flit[W-1:0];
    assign w_src     = w_flit[2*W-1:W];
    assign w_op      = w_flit[2*W];
    assign w_idx     = w_flit[2*W+8:2*W+1];
    assign w_tag     = w_flit[2*W+16:2*W+9];
    assign w_own     = (w_dst == OWN_ID);
    assign w_idx_oob = ({1'b0, w_idx} >= NUM_REGS);
    // Writes to the read-only register 0 are reported as errors as well.
    assign w_req_err = w_idx_oob || (w_op && (w_idx == 8'd0));
    assign w_accept  = network_valid_i && network_go_o;

    // Request status bit and payload bits above the fields are ignored.
    assign w_unused_bits = ^network_data_i;

    assign err_count_o = r_err;

    // Register-file read mux; register 0 returns the tile address.
    always_comb begin
        w_rd_val = REG0_VAL;
        for (int r = 1; r < N; r++) begin
            if (w_idx == 8'(r)) begin
                w_rd_val = r_regs[r];
            end
        end
    end

    // Flatten the register file onto the status output.
    always_comb begin
        filereg_q_o            = '0;
        filereg_q_o[RW-1:0]    = REG0_VAL;
        for (int r = 1; r < N; r++) begin
            filereg_q_o[r*RW +: RW] = r_regs[r];
        end
    end

    // Next-state, handshake and response-flit generation.
    always_comb begin
        w_state_next    = r_state;
        w_capture       = 1'b0;
        w_err_inc       = 1'b0;
        w_wr_en         = 1'b0;
        network_go_o    = 1'b0;
        network_valid_o = 1'b0;
        network_data_o  = '0;
        case (r_state)
            S_IDLE: begin
                network_go_o = r_go_en;
                if (w_accept) begin
                    if (!w_own || (w_type == FT_BODY) || (w_type == FT_TAIL) ||
                        ((w_type == FT_HEADER_TAIL) && w_op) ||
                        ((w_type == FT_HEADER) && !w_op)) begin
                        w_err_inc = 1'b1;
                    end else if (w_type == FT_HEADER_TAIL) begin
                        w_capture    = 1'b1;
                        w_err_inc    = w_req_err;
                        w_state_next = S_RESP_HDR;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                network_go_o = r_go_en;
                if (w_accept) begin
                    if (w_type == FT_TAIL) begin
                        w_wr_en      = !r_status;
                        w_err_inc    = r_status;
                        w_state_next = S_RESP_HDR;
                    end else begin
                        w_err_inc    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_RESP_HDR: begin
                network_valid_o = 1'b1;
                network_data_o  = {(r_op ? FT_HEADER_TAIL : FT_HEADER),
                                   make_header(r_req_src, r_op, r_idx, r_tag, r_status)};
                if (network_go_i) begin
                    w_state_next = r_op ? S_IDLE : S_RESP_TAIL;
                end
            end
            S_RESP_TAIL: begin
                network_valid_o = 1'b1;
                network_data_o  = {FT_TAIL, make_tail(r_rdata)};
                if (network_go_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register plus the enable that holds go low until after reset.
    always_ff @(posedge clk_network_i or posedge rst_network_i) begin
        if (rst_network_i) begin
            r_state <= S_IDLE;
            r_go_en <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_go_en <= 1'b1;
        end
    end

    // Capture the request fields and read data when a request header is accepted.
    always_ff @(posedge clk_network_i or posedge rst_network_i) begin
        if (rst_network_i) begin
            r_req_src <= '0;
            r_op      <= 1'b0;
            r_idx     <= '0;
            r_tag     <= '0;
            r_status  <= 1'b0;
            r_rdata   <= '0;
        end else if (w_capture) begin
            r_req_src <= w_src;
            r_op      <= w_op;
            r_idx     <= w_idx;
            r_tag     <= w_tag;
            r_status  <= w_req_err;
            r_rdata   <= w_idx_oob ? '0 : w_rd_val;
        end
    end

    // Commit a legal write when its tail flit arrives.
    always_ff @(posedge clk_network_i or posedge rst_network_i) begin
        if (rst_network_i) begin
            for (int r = 1; r < N; r++) begin
                r_regs[r] <= '0;
            end
        end else if (w_wr_en) begin
            for (int r = 1; r < N; r++) begin
                if (r_idx == 8'(r)) begin
                    r_regs[r] <= w_flit[RW-1:0];
                end
            end
        end
    end

    // Saturating error counter; at most one event per cycle.
    always_ff @(posedge clk_network_i or posedge rst_network_i) begin
        if (rst_network_i) begin
            r_err <= '0;
        end else if (w_err_inc && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

endmodule

// File: tb/tb_noc_filereg_responder.sv
// Directed testbench for noc_filereg_responder (ID=0, W=4, 64-bit flits,
// 16 registers of 32 bits).
module tb_noc_filereg_responder;

    localparam logic [1:0] HD = 2'b00;
    localparam logic [1:0] BD = 2'b01;
    localparam logic [1:0] TL = 2'b10;
    localparam logic [1:0] HT = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [65:0] data_i = '0;
    logic        go_o;
    logic        valid_o;
    logic [65:0] data_o;
    logic        go_i = 1'b0;
    logic [511:0] q;
    logic [7:0]  err;

    int tests = 0;
    int fails = 0;

    noc_filereg_responder #(
        .NetworkSwitchAddressId(0),
        .NetworkSwitchAddressIdWidth(4),
        .NetworkFlitWidth(64),
        .NetworkFlitTypeWidth(2),
        .NumberOfRegisters(16),
        .RegisterWidth(32)
    ) dut (
        .clk_network_i(clk),
        .rst_network_i(rst),
        .network_valid_i(valid_i),
        .network_data_i(data_i),
        .network_go_o(go_o),
        .network_valid_o(valid_o),
        .network_data_o(data_o),
        .network_go_i(go_i),
        .filereg_q_o(q),
        .err_count_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] hdr(input logic [3:0] dst, input logic [3:0] src,
                                        input logic op, input logic [7:0] idx,
                                        input logic [7:0] tag, input logic st);
        logic [63:0] f;
        f = '0;
        f[3:0] = dst; f[7:4] = src; f[8] = op; f[16:9] = idx; f[24:17] = tag; f[25] = st;
        return f;
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one flit and hold it until accepted (bounded).
    task automatic send_flit(input logic [1:0] t, input logic [63:0] f);
        bit done;
        done = 0;
        valid_i = 1'b1;
        data_i  = {t, f};
        for (int c = 0; c < 20 && !done; c++) begin
            if (go_o) done = 1;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        data_i  = '0;
        if (!done) check("send_timeout", 66'd0, 66'd1);
    endtask

    // Wait (bounded) for a response flit, then accept it.
    task automatic get_resp(output logic [65:0] d);
        bit seen;
        seen = 0;
        d = '0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (valid_o) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) begin
            check("resp_timeout", 66'd0, 66'd1);
        end else begin
            d = data_o;
            go_i = 1'b1;
            @(posedge clk); #1;
            go_i = 1'b0;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  idx;
        logic [3:0]  src;
        logic [7:0]  tag;
        logic [31:0] wdata;
        bit          st;
        logic [31:0] rdata;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [65:0] d;
        logic [63:0] f;

        vecs[0] = '{1, 8'd5,   4'd3, 8'h2A, 32'hDEADBEEF, 0, 32'h0,        8'd0};
        vecs[1] = '{0, 8'd5,   4'd3, 8'h2B, 32'h0,        0, 32'hDEADBEEF, 8'd0};
        vecs[2] = '{1, 8'd15,  4'd7, 8'h01, 32'h12345678, 0, 32'h0,        8'd0};
        vecs[3] = '{0, 8'd15,  4'd9, 8'h02, 32'h0,        0, 32'h12345678, 8'd0};
        vecs[4] = '{0, 8'd20,  4'd1, 8'h03, 32'h0,        1, 32'h0,        8'd1};
        vecs[5] = '{1, 8'd0,   4'd2, 8'h04, 32'hFFFFFFFF, 1, 32'h0,        8'd2};
        vecs[6] = '{0, 8'd0,   4'd2, 8'h05, 32'h0,        0, 32'h0,        8'd2};
        vecs[7] = '{1, 8'd16,  4'd4, 8'h06, 32'h55AA55AA, 1, 32'h0,        8'd3};
        vecs[8] = '{0, 8'd1,   4'd4, 8'h07, 32'h0,        0, 32'h0,        8'd3};
        vecs[9] = '{0, 8'd255, 4'hF, 8'hFF, 32'h0,        1, 32'h0,        8'd4};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_go", {65'd0, go_o}, 66'd0);
        check("rst_valid", {65'd0, valid_o}, 66'd0);
        check("rst_data", data_o, 66'd0);
        check("rst_err", {58'd0, err}, 66'd0);
        check("rst_q", {65'd0, |q}, 66'd0);
        rst = 1'b0;
        #1;
        check("go_before_edge", {65'd0, go_o}, 66'd0);
        @(posedge clk); #1;
        check("go_after_edge", {65'd0, go_o}, 66'd1);

        // Table-driven transactions
        for (int i = 0; i < 10; i++) begin
            f = hdr(4'd0, vecs[i].src, vecs[i].wr, vecs[i].idx, vecs[i].tag, 1'b0);
            if (vecs[i].wr) begin
                send_flit(HD, f);
                send_flit(TL, {32'd0, vecs[i].wdata});
                get_resp(d);
                check($sformatf("v%0d_wr_hdr", i), d,
                      {HT, hdr(vecs[i].src, 4'd0, 1'b1, vecs[i].idx, vecs[i].tag, vecs[i].st)});
            end else begin
                send_flit(HT, f);
                get_resp(d);
                check($sformatf("v%0d_rd_hdr", i), d,
                      {HD, hdr(vecs[i].src, 4'd0, 1'b0, vecs[i].idx, vecs[i].tag, vecs[i].st)});
                get_resp(d);
                check($sformatf("v%0d_rd_tail", i), d, {TL, 32'd0, vecs[i].rdata});
            end
            check($sformatf("v%0d_err", i), {58'd0, err}, {58'd0, vecs[i].err});
        end
        check("q_reg5", {34'd0, q[5*32 +: 32]}, {34'd0, 32'hDEADBEEF});
        check("q_reg15", {34'd0, q[15*32 +: 32]}, {34'd0, 32'h12345678});
        check("q_reg0", {34'd0, q[31:0]}, 66'd0);

        // Misaddressed read and a lone TAIL are dropped
        send_flit(HT, hdr(4'd5, 4'd1, 1'b0, 8'd5, 8'h10, 1'b0));
        send_flit(TL, 64'h1234);
        repeat (3) begin
            check("drop_no_valid", {65'd0, valid_o}, 66'd0);
            @(posedge clk); #1;
        end
        check("drop_err", {58'd0, err}, 66'd6);
        check("drop_go", {65'd0, go_o}, 66'd1);

        // Backpressure on a read response
        send_flit(HT, hdr(4'd0, 4'd6, 1'b0, 8'd5, 8'h33, 1'b0));
        valid_i = 1'b1;
        data_i  = {TL, 64'hBAD};
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid_%0d", c), {65'd0, valid_o}, 66'd1);
            check($sformatf("bp_hdr_%0d", c), data_o, {HD, hdr(4'd6, 4'd0, 1'b0, 8'd5, 8'h33, 1'b0)});
            check($sformatf("bp_go_%0d", c), {65'd0, go_o}, 66'd0);
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        data_i  = '0;
        check("bp_err", {58'd0, err}, 66'd6);
        get_resp(d);
        check("bp_hdr_acc", d, {HD, hdr(4'd6, 4'd0, 1'b0, 8'd5, 8'h33, 1'b0)});
        get_resp(d);
        check("bp_tail", d, {TL, 32'd0, 32'hDEADBEEF});

        // Write header followed by a HEADER_TAIL aborts the write
        send_flit(HD, hdr(4'd0, 4'd2, 1'b1, 8'd6, 8'h44, 1'b0));
        send_flit(HT, {32'd0, 32'hCAFEF00D} | hdr(4'd0, 4'd2, 1'b0, 8'd6, 8'h45, 1'b0));
        repeat (3) begin
            check("abort_no_valid", {65'd0, valid_o}, 66'd0);
            @(posedge clk); #1;
        end
        check("abort_err", {58'd0, err}, 66'd7);
        check("abort_go", {65'd0, go_o}, 66'd1);
        check("abort_reg6", {34'd0, q[6*32 +: 32]}, 66'd0);

        // Reset while the read tail is pending
        send_flit(HD, hdr(4'd0, 4'd2, 1'b1, 8'd1, 8'h09, 1'b0));
        send_flit(TL, {32'd0, 32'hA5A5A5A5});
        get_resp(d);
        check("pre_rst_wr", d, {HT, hdr(4'd2, 4'd0, 1'b1, 8'd1, 8'h09, 1'b0)});
        check("pre_rst_reg1", {34'd0, q[63:32]}, {34'd0, 32'hA5A5A5A5});
        send_flit(HT, hdr(4'd0, 4'd2, 1'b0, 8'd1, 8'h0A, 1'b0));
        get_resp(d);
        check("pre_rst_valid", {65'd0, valid_o}, 66'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {65'd0, valid_o}, 66'd0);
        check("mid_rst_data", data_o, 66'd0);
        check("mid_rst_reg1", {34'd0, q[63:32]}, 66'd0);
        check("mid_rst_err", {58'd0, err}, 66'd0);
        check("mid_rst_go", {65'd0, go_o}, 66'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_flit(HT, hdr(4'd0, 4'd8, 1'b0, 8'd1, 8'h0B, 1'b0));
        get_resp(d);
        check("post_rst_hdr", d, {HD, hdr(4'd8, 4'd0, 1'b0, 8'd1, 8'h0B, 1'b0)});
        get_resp(d);
        check("post_rst_tail", d, {TL, 64'd0});

        // Error counter saturates at 255
        for (int k = 0; k < 260; k++) send_flit(BD, 64'd0);
        check("err_sat", {58'd0, err}, 66'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
